mdu_iter: RTL

- Iterative unsigned multiply/divide unit in the execute stage of the pipelined core.
- It is the responder on the pipeline-register enable/clear interface. It raises a stall that the hazard logic uses to deassert enable on the F/D/E pipeline registers while an operation runs.
- It accepts a flush that mirrors the clear of the E-stage register.
- It computes one result bit per cycle and returns the result with a one-cycle done pulse.

---
 rtl/mdu_iter.sv | 115 +++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply/divide for the execute stage: one result bit per cycle,
// stalls the F/D/E registers while running, killed by the E-stage clear (flush).
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_count;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_result;

  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic [WIDTH:0]     w_shift;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt;
  logic [WIDTH-1:0]   w_res;
  logic               w_last;
  logic               w_accept;

  // Shift-add: add b into the upper half when the current multiplier bit is set, then shift right.
  assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_b} : '0);
  assign w_prod_nxt = {w_mul_sum, r_prod[WIDTH-1:1]};

  // Restoring divide: the true difference is below 2^WIDTH whenever it is kept,
  // so a WIDTH-bit subtract suffices once the WIDTH+1-bit compare has passed.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_qbit    = (w_shift >= {1'b0, r_b});
  assign w_rem_nxt = w_qbit ? (w_shift[WIDTH-1:0] - r_b) : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_qbit};

  always_comb begin
    w_res = w_rem_nxt;
    case (r_op)
      2'b00:   w_res = w_prod_nxt[WIDTH-1:0];
      2'b01:   w_res = w_prod_nxt[2*WIDTH-1:WIDTH];
      2'b10:   w_res = w_quo_nxt;
      default: w_res = w_rem_nxt;
    endcase
  end

  assign w_last   = (r_count == CW'(WIDTH-1));
  assign w_accept = (r_state == S_IDLE) & start & ~flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_op     <= '0;
      r_b      <= '0;
      r_prod   <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= op;
            r_b     <= b;
            r_prod  <= {{WIDTH{1'b0}}, a};
            r_rem   <= '0;
            r_quo   <= a;
            r_count <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_prod  <= w_prod_nxt;
            r_rem   <= w_rem_nxt;
            r_quo   <= w_quo_nxt;
            r_count <= r_count + 1'b1;
            if (w_last) begin
              r_result <= w_res;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall  = w_accept | (r_state == S_RUN);
  assign busy   = (r_state == S_RUN);
  assign done   = (r_state == S_DONE) & ~flush;
  assign result = r_result;

endmodule
